// File: rtl/gm64_mem_pkg.sv
// Shared types and widths for the memory-controller request interface.
// Used by the PSRAM stub responder, memCtrl and the gm64 top level.
package gm64_mem_pkg;

  // Request-interface widths
  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  // Width of the wait-state counter; LATENCY is limited to 1..255
  localparam int LAT_W = 8;

  // Responder transaction state
  typedef enum logic {
    rstIdle = 1'b0,
    rstBusy = 1'b1
  } RespState;

endpackage

// File: rtl/psram_stub_array.sv
// Single-port synchronous byte RAM backing the PSRAM stub.
// Write enable and read enable are mutually exclusive. The read data register
// only updates on a read, so it holds the last read result between reads.
// Contents are set by the declaration initialiser only and survive reset.
module psram_stub_array
  import gm64_mem_pkg::*;
#(
  parameter int                ADDR_BITS  = 10,
  parameter logic [DATA_W-1:0] FILL_VALUE = 8'h00
) (
  input  logic                 clkSys,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem_r [DEPTH] = '{default: FILL_VALUE};
  logic [DATA_W-1:0] rdata_r;

  // Array write port; deliberately outside reset so contents are retained
  always_ff @(posedge clkSys) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read port; cleared by reset, otherwise holds the last read
  always_ff @(posedge clkSys or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/psram_stub_responder.sv
// Target side of the CE/write/address/data + busy/dataReady handshake.
// Accepts one request per falling edge of i_cs, holds o_busy for LATENCY
// cycles, then commits the access to the on-chip array. Requests arriving
// while busy are dropped and flagged on the sticky o_overrun output.
module psram_stub_responder
  import gm64_mem_pkg::*;
#(
  parameter int                ADDR_BITS  = 10,
  parameter int                LATENCY    = 4,
  parameter logic [DATA_W-1:0] FILL_VALUE = 8'h00
) (
  input  logic              i_clkRAM,
  input  logic              reset,
  input  logic              i_cs,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_dataToWrite,
  output logic [DATA_W-1:0] o_dataRead,
  output logic              o_busy,
  output logic              o_dataReady,
  output logic              o_overrun
);

  // Counter start value: commit happens LATENCY edges after acceptance
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);

  RespState              state_r;
  logic [LAT_W-1:0]      cnt_r;
  logic                  cs_prev_r;
  logic                  wr_r;
  logic [ADDR_BITS-1:0]  addr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic                  busy_r;
  logic                  ready_r;
  logic                  overrun_r;

  logic                  req_s;
  logic                  commit_s;
  logic                  we_s;
  logic                  re_s;
  logic [DATA_W-1:0]     rdata_s;

  // Upper address bits alias onto the array and are intentionally dropped
  logic                  unused_addr_s;
  assign unused_addr_s = ^i_address[ADDR_W-1:ADDR_BITS];

  // A request is a high-to-low transition of the active-low strobe
  assign req_s    = cs_prev_r & ~i_cs;
  assign commit_s = (state_r == rstBusy) && (cnt_r == {LAT_W{1'b0}});

  // Array strobes fire only on the commit edge of an in-flight transaction
  always_comb begin
    we_s = 1'b0;
    re_s = 1'b0;
    if (commit_s) begin
      we_s = wr_r;
      re_s = ~wr_r;
    end else begin
      we_s = 1'b0;
      re_s = 1'b0;
    end
  end

  // Transaction FSM: edge detect, request latch, wait-state count, flags
  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) begin
      state_r   <= rstIdle;
      cnt_r     <= {LAT_W{1'b0}};
      cs_prev_r <= 1'b1;
      wr_r      <= 1'b0;
      addr_r    <= {ADDR_BITS{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
      ready_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      cs_prev_r <= i_cs;
      case (state_r)
        rstIdle: begin
          if (req_s) begin
            wr_r    <= i_write;
            addr_r  <= i_address[ADDR_BITS-1:0];
            wdata_r <= i_dataToWrite;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
            cnt_r   <= LAT_INIT;
            state_r <= rstBusy;
          end
        end
        rstBusy: begin
          // A new strobe while busy (even on the commit edge) is dropped
          if (req_s) begin
            overrun_r <= 1'b1;
          end
          if (cnt_r == {LAT_W{1'b0}}) begin
            busy_r  <= 1'b0;
            ready_r <= ~wr_r;
            state_r <= rstIdle;
          end else begin
            cnt_r <= cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
          cnt_r   <= {LAT_W{1'b0}};
          state_r <= rstIdle;
        end
      endcase
    end
  end

  psram_stub_array #(
    .ADDR_BITS  (ADDR_BITS),
    .FILL_VALUE (FILL_VALUE)
  ) u_array (
    .clkSys (i_clkRAM),
    .rst_n  (reset),
    .we     (we_s),
    .re     (re_s),
    .addr   (addr_r),
    .wdata  (wdata_r),
    .rdata  (rdata_s)
  );

  assign o_dataRead  = rdata_s;
  assign o_busy      = busy_r;
  assign o_dataReady = ready_r;
  assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_psram_stub_responder.sv
// Directed bench for psram_stub_responder: default LATENCY=4 instance plus a
// LATENCY=1 instance sharing clock, reset and the write/address/data buses.
module tb_psram_stub_responder;

  logic        clk_s = 1'b0;
  logic        rst_n_s;
  logic        cs0_s, cs1_s;
  logic        wr_s;
  logic [23:0] addr_s;
  logic [7:0]  wd_s;

  logic [7:0]  dr0_s, dr1_s;
  logic        busy0_s, busy1_s;
  logic        rdy0_s, rdy1_s;
  logic        ovr0_s, ovr1_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_s = ~clk_s;

  psram_stub_responder #(.ADDR_BITS(10), .LATENCY(4), .FILL_VALUE(8'h00)) u_dut (
    .i_clkRAM      (clk_s),
    .reset         (rst_n_s),
    .i_cs          (cs0_s),
    .i_write       (wr_s),
    .i_address     (addr_s),
    .i_dataToWrite (wd_s),
    .o_dataRead    (dr0_s),
    .o_busy        (busy0_s),
    .o_dataReady   (rdy0_s),
    .o_overrun     (ovr0_s)
  );

  psram_stub_responder #(.ADDR_BITS(10), .LATENCY(1), .FILL_VALUE(8'h00)) u_dut_lat1 (
    .i_clkRAM      (clk_s),
    .reset         (rst_n_s),
    .i_cs          (cs1_s),
    .i_write       (wr_s),
    .i_address     (addr_s),
    .i_dataToWrite (wd_s),
    .o_dataRead    (dr1_s),
    .o_busy        (busy1_s),
    .o_dataReady   (rdy1_s),
    .o_overrun     (ovr1_s)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One request on instance sel. Strobe is held low for hold_low samples and
  // pulsed low again for one cycle at sample pulse_at (-1 for none).
  // Returns the number of samples with busy high and with ready high while busy.
  task automatic txn(input int sel, input logic w, input logic [23:0] a,
                     input logic [7:0] d, input int hold_low, input int pulse_at,
                     output int busy_n, output int rdy_in_busy);
    logic done;
    logic b, r;
    @(negedge clk_s);
    wr_s = w; addr_s = a; wd_s = d;
    if (sel == 0) cs0_s = 1'b0; else cs1_s = 1'b0;
    busy_n = 0; rdy_in_busy = 0; done = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk_s);
      b = (sel == 0) ? busy0_s : busy1_s;
      r = (sel == 0) ? rdy0_s  : rdy1_s;
      if (b) begin
        busy_n++;
        if (r) rdy_in_busy++;
      end
      if (sel == 0) cs0_s = !((k < hold_low) || (k == pulse_at));
      else          cs1_s = !((k < hold_low) || (k == pulse_at));
      if (!b && busy_n > 0 && k >= hold_low && k > pulse_at) done = 1'b1;
    end
    chk("txn_done", {31'd0, done}, 32'd1);
    if (sel == 0) cs0_s = 1'b1; else cs1_s = 1'b1;
  endtask

  initial begin
    int bn, rb;
    rst_n_s = 1'b0; cs0_s = 1'b1; cs1_s = 1'b1;
    wr_s = 1'b0; addr_s = 24'h0; wd_s = 8'h00;
    repeat (2) @(negedge clk_s);
    chk("rst_busy",  {31'd0, busy0_s}, 32'd0);
    chk("rst_ready", {31'd0, rdy0_s},  32'd0);
    chk("rst_data",  {24'd0, dr0_s},   32'h00);
    chk("rst_ovr",   {31'd0, ovr0_s},  32'd0);
    rst_n_s = 1'b1;
    @(negedge clk_s);

    // Write aa to 1
    txn(0, 1'b1, 24'h000001, 8'haa, 1, -1, bn, rb);
    chk("wr1_busy_cycles", bn, 32'd4);
    chk("wr1_ready_in_busy", rb, 32'd0);
    chk("wr1_ready", {31'd0, rdy0_s}, 32'd0);
    chk("wr1_ovr", {31'd0, ovr0_s}, 32'd0);

    // Read it back, outputs hold
    txn(0, 1'b0, 24'h000001, 8'h00, 1, -1, bn, rb);
    chk("rd1_busy_cycles", bn, 32'd4);
    chk("rd1_ready_in_busy", rb, 32'd0);
    chk("rd1_ready", {31'd0, rdy0_s}, 32'd1);
    chk("rd1_data", {24'd0, dr0_s}, 32'haa);
    chk("rd1_busy", {31'd0, busy0_s}, 32'd0);
    repeat (3) @(negedge clk_s);
    chk("rd1_hold_ready", {31'd0, rdy0_s}, 32'd1);
    chk("rd1_hold_data", {24'd0, dr0_s}, 32'haa);

    // Address alias: write 403, read 3
    txn(0, 1'b1, 24'h000403, 8'h55, 1, -1, bn, rb);
    chk("wr_alias_ready", {31'd0, rdy0_s}, 32'd0);
    txn(0, 1'b0, 24'h000003, 8'h00, 1, -1, bn, rb);
    chk("rd_alias_data", {24'd0, dr0_s}, 32'h55);
    chk("rd_alias_ready", {31'd0, rdy0_s}, 32'd1);

    // Untouched location reads the fill value
    txn(0, 1'b0, 24'h000200, 8'h00, 1, -1, bn, rb);
    chk("rd_fill_data", {24'd0, dr0_s}, 32'h00);

    // Overrun: second strobe two cycles into a busy read
    txn(0, 1'b0, 24'h000001, 8'h00, 1, 2, bn, rb);
    chk("ovr_busy_cycles", bn, 32'd4);
    chk("ovr_data", {24'd0, dr0_s}, 32'haa);
    chk("ovr_ready", {31'd0, rdy0_s}, 32'd1);
    chk("ovr_flag", {31'd0, ovr0_s}, 32'd1);
    @(negedge clk_s);
    chk("ovr_no_extra_txn", {31'd0, busy0_s}, 32'd0);
    repeat (3) @(negedge clk_s);
    chk("ovr_sticky", {31'd0, ovr0_s}, 32'd1);

    // Strobe held low for 20 cycles: one transaction only
    txn(0, 1'b0, 24'h000003, 8'h00, 20, -1, bn, rb);
    chk("hold_busy_cycles", bn, 32'd4);
    chk("hold_ready", {31'd0, rdy0_s}, 32'd1);
    chk("hold_data", {24'd0, dr0_s}, 32'h55);

    // Reset aborts an in-flight write
    txn(0, 1'b1, 24'h000010, 8'h22, 1, -1, bn, rb);
    txn(0, 1'b0, 24'h000010, 8'h00, 1, -1, bn, rb);
    chk("pre_abort_data", {24'd0, dr0_s}, 32'h22);
    @(negedge clk_s);
    wr_s = 1'b1; addr_s = 24'h000010; wd_s = 8'h11; cs0_s = 1'b0;
    @(negedge clk_s);
    cs0_s = 1'b1;
    @(negedge clk_s);
    chk("abort_busy_before", {31'd0, busy0_s}, 32'd1);
    rst_n_s = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy0_s}, 32'd0);
    chk("abort_ready", {31'd0, rdy0_s}, 32'd0);
    chk("abort_data", {24'd0, dr0_s}, 32'h00);
    chk("abort_ovr", {31'd0, ovr0_s}, 32'd0);
    @(negedge clk_s);
    rst_n_s = 1'b1;
    repeat (6) @(negedge clk_s);
    chk("abort_idle_busy", {31'd0, busy0_s}, 32'd0);
    txn(0, 1'b0, 24'h000010, 8'h00, 1, -1, bn, rb);
    chk("abort_rd_data", {24'd0, dr0_s}, 32'h22);

    // LATENCY=1 instance
    txn(1, 1'b1, 24'h000005, 8'h77, 1, -1, bn, rb);
    chk("lat1_wr_busy_cycles", bn, 32'd1);
    chk("lat1_wr_ready", {31'd0, rdy1_s}, 32'd0);
    txn(1, 1'b0, 24'h000005, 8'h00, 1, -1, bn, rb);
    chk("lat1_rd_busy_cycles", bn, 32'd1);
    chk("lat1_rd_data", {24'd0, dr1_s}, 32'h77);
    chk("lat1_rd_ready", {31'd0, rdy1_s}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
